// File: rtl/lzc_stream_pkg.sv
// ============================================================================
//  Module      : lzc_pkg
//  Description : Shared types and width helpers for the streaming LZC.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lzc_pkg;

    typedef enum logic [0:0] {
        ACC   = 1'b0,
        DRAIN = 1'b1
    } fsm_t;

    // Result width: must hold 0..width*words inclusive.
    function automatic int cnt_w(input int width, input int words);
        return $clog2(width * words) + 1;
    endfunction

    // Per-word count width: must hold 0..width inclusive.
    function automatic int lead_cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lzc_stream_if.sv
// ============================================================================
//  Module      : lzc_stream_if
//  Description : Word-in / result-out handshake bundle for lzc_stream.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lzc_stream_if
    import lzc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int WORDS = 4,
    parameter int CNT_W = cnt_w(WIDTH, WORDS)
);
    logic [WIDTH-1:0] i_data;
    logic             i_valid;
    logic             i_last;
    logic             i_mode;
    logic             i_ready;
    logic [CNT_W-1:0] o_count;
    logic             o_all;
    logic             o_valid;
    logic             o_ready;

    modport slave (
        input  i_data, i_valid, i_last, i_mode, o_ready,
        output i_ready, o_count, o_all, o_valid
    );

    modport master (
        output i_data, i_valid, i_last, i_mode, o_ready,
        input  i_ready, o_count, o_all, o_valid
    );
endinterface

`default_nettype wire

// File: rtl/lzc_stream_word.sv
// ============================================================================
//  Module      : lzc_word
//  Description : Combinational leading-zero count of one WIDTH-bit word using
//                a binary priority tree; returns WIDTH for an all-zero word.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lzc_word
    import lzc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic [WIDTH-1:0]             i_data,
    output logic      [lead_cnt_w(WIDTH)-1:0] o_count
);
    localparam int L = $clog2(WIDTH);
    localparam int P = 1 << L;
    localparam logic [L:0] C_ALL = (L + 1)'(P);

    // Heap-indexed tree: node k has children 2k (more significant) and 2k+1.
    logic         w_v [1:2*P-1];
    logic [L-1:0] w_c [1:2*P-1];

    for (genvar i = 0; i < P; i++) begin : g_leaf
        // Padding leaves read as '1' so a short word stops counting at WIDTH.
        if (i < WIDTH) begin : g_real
            assign w_v[P+i] = i_data[WIDTH-1-i];
        end else begin : g_pad
            assign w_v[P+i] = 1'b1;
        end
        assign w_c[P+i] = '0;
    end

    for (genvar k = 1; k < P; k++) begin : g_node
        localparam int         HT     = L - ($clog2(k + 1) - 1);
        localparam logic [L-1:0] C_HALF = L'(1 << (HT - 1));
        assign w_v[k] = w_v[2*k] | w_v[2*k+1];
        assign w_c[k] = w_v[2*k] ? w_c[2*k] : (C_HALF + w_c[2*k+1]);
    end

    assign o_count = w_v[1] ? {1'b0, w_c[1]} : C_ALL;

endmodule

`default_nettype wire

// File: rtl/lzc_stream.sv
// ============================================================================
//  Module      : lzc_stream
//  Description : Streaming leading-zero/one counter over multi-word frames.
//                Define LZC_EARLY_OUT_EN to emit the result on the first word
//                holding a terminating bit and discard the rest of the frame.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lzc_stream
    import lzc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int WORDS = 4
) (
    input  wire logic   clk,
    input  wire logic   rst,
    lzc_stream_if.slave bus
);
    localparam int CNT_W = cnt_w(WIDTH, WORDS);
    localparam int LW    = lead_cnt_w(WIDTH);
    localparam int WC_W  = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [WC_W-1:0] C_LAST_WORD = WC_W'(WORDS - 1);
    localparam logic [LW-1:0]   C_FULL      = LW'(WIDTH);

    fsm_t             r_state;
    fsm_t             w_state_next;
    logic [CNT_W-1:0] r_acc;
    logic [CNT_W-1:0] w_acc_next;
    logic [CNT_W-1:0] r_out_count;
    logic [WC_W-1:0]  r_words;
    logic             r_found;
    logic             w_found_next;
    logic             r_mode;
    logic             w_mode;
    logic             r_out_valid;
    logic             r_out_all;
    logic [WIDTH-1:0] w_word;
    logic [LW-1:0]    w_lead;
    logic             w_ready;
    logic             w_accept;
    logic             w_end;
    logic             w_load;
    logic             w_clear;
    logic             w_frame_done;

    assign w_ready  = !rst && !(r_out_valid && !bus.o_ready);
    assign w_accept = bus.i_valid && w_ready;
    assign w_end    = bus.i_last || (r_words == C_LAST_WORD);

    // Polarity is fixed by the first word; later i_mode values are ignored.
    assign w_mode = (r_words == '0) ? bus.i_mode : r_mode;
    assign w_word = bus.i_data ^ {WIDTH{w_mode}};

    lzc_word #(
        .WIDTH (WIDTH)
    ) u_word (
        .i_data  (w_word),
        .o_count (w_lead)
    );

    assign w_acc_next   = r_found ? r_acc : (r_acc + CNT_W'(w_lead));
    assign w_found_next = r_found || (w_lead != C_FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
`ifdef LZC_EARLY_OUT_EN
        case (r_state)
            ACC:     if (w_accept && w_found_next && !w_end) w_state_next = DRAIN;
            DRAIN:   if (w_accept && w_end)                  w_state_next = ACC;
            default:                                         w_state_next = ACC;
        endcase
`else
        w_state_next = ACC;
`endif
    end

    always_comb begin
        w_load       = 1'b0;
        w_clear      = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            ACC: begin
                w_frame_done = w_accept && w_end;
`ifdef LZC_EARLY_OUT_EN
                w_load       = w_accept && (w_end || w_found_next);
`else
                w_load       = w_accept && w_end;
`endif
                w_clear      = w_load;
            end
            DRAIN: begin
                w_frame_done = w_accept && w_end;
            end
            default: begin
                w_frame_done = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_found     <= 1'b0;
            r_words     <= '0;
            r_mode      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_count <= '0;
            r_out_all   <= 1'b0;
        end else begin
            if (w_accept) begin
                if (r_words == '0) begin
                    r_mode <= bus.i_mode;
                end
                r_words <= w_frame_done ? '0 : (r_words + 1'b1);
                if (w_clear) begin
                    r_acc   <= '0;
                    r_found <= 1'b0;
                end else if (r_state == ACC) begin
                    r_acc   <= w_acc_next;
                    r_found <= w_found_next;
                end
            end
            // A load can coincide with the consumer draining the previous result.
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_count <= w_acc_next;
                r_out_all   <= !w_found_next;
            end else if (bus.o_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.i_ready = w_ready;
    assign bus.o_valid = r_out_valid && !rst;
    assign bus.o_count = rst ? '0 : r_out_count;
    assign bus.o_all   = r_out_all && !rst;

endmodule

`default_nettype wire

// File: tb/tb_lzc_stream.sv
// ============================================================================
//  Module      : tb_lzc_stream
//  Description : Self-checking bench for lzc_stream against a bit-serial model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lzc_stream;
    localparam int WIDTH = 8;
    localparam int WORDS = 4;
    localparam int CNT_W = 6;

    logic clk = 1'b0;
    logic rst;
    logic tb_ready;
    logic rnd_ready = 1'b0;
    logic rnd_bit   = 1'b1;

    always #5 clk = ~clk;

    lzc_stream_if #(.WIDTH(WIDTH), .WORDS(WORDS), .CNT_W(CNT_W)) bus ();

    lzc_stream #(
        .WIDTH (WIDTH),
        .WORDS (WORDS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.o_ready = rnd_ready ? rnd_bit : tb_ready;

    int n_vec  = 0;
    int n_fail = 0;

    logic [CNT_W:0] exp_q [$];
    logic [CNT_W:0] got_q [$];

    always @(posedge clk) begin
        #1;
        rnd_bit = ($urandom_range(0, 2) != 0);
    end

    always @(negedge clk) begin
        if (!rst && bus.o_valid && bus.o_ready) got_q.push_back({bus.o_all, bus.o_count});
    end

    // Frame viewed as one bit string, MSB of word 0 first.
    function automatic logic [CNT_W:0] model(input logic [7:0] w [4], input int n, input logic mode);
        logic [7:0] cur;
        for (int i = 0; i < n * WIDTH; i++) begin
            cur = w[i / WIDTH];
            if (cur[WIDTH - 1 - (i % WIDTH)] != mode) return {1'b0, CNT_W'(i)};
        end
        return {1'b1, CNT_W'(n * WIDTH)};
    endfunction

    task automatic drive_word(input logic [7:0] d, input logic last, input logic mode);
        bit ok;
        ok = 1'b0;
        bus.i_data  = d;
        bus.i_last  = last;
        bus.i_mode  = mode;
        bus.i_valid = 1'b1;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = bus.i_ready;
        end
        if (!ok) begin
            n_vec++;
            n_fail++;
            $display("FAIL accept_timeout: i_ready=%0b, required 1", bus.i_ready);
        end
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
        bus.i_data  = 8'($urandom);
        bus.i_mode  = 1'($urandom);
    endtask

    task automatic send_frame(input logic [7:0] w [4], input int n, input logic mode,
                              input int mingap, input int maxgap);
        logic last;
        for (int i = 0; i < n; i++) begin
            last = (i == n - 1) ? ((n < WORDS) || 1'($urandom)) : 1'b0;
            drive_word(w[i], last, (i == 0) ? mode : 1'($urandom));
            if (i < n - 1) begin
                repeat ($urandom_range(mingap, maxgap)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        exp_q.push_back(model(w, n, mode));
    endtask

    task automatic wait_results();
        for (int t = 0; t < 500 && got_q.size() < exp_q.size(); t++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        tb_ready    = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
        bus.i_mode  = 1'b0;
        bus.i_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid: got %0b, required 0", bus.o_valid); end
        n_vec++; if (bus.o_count !== '0)   begin n_fail++; $display("FAIL reset_o_count: got %0d, required 0", bus.o_count); end
        n_vec++; if (bus.o_all !== 1'b0)   begin n_fail++; $display("FAIL reset_o_all: got %0b, required 0", bus.o_all); end
        n_vec++; if (bus.i_ready !== 1'b0) begin n_fail++; $display("FAIL reset_i_ready: got %0b, required 0", bus.i_ready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.i_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_i_ready: got %0b, required 1", bus.i_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [7:0]     frm [4];
        logic [CNT_W:0] e, g;
        frm = '{8'h3F, 8'h00, 8'h0F, 8'h01};
        send_frame(frm, 4, 1'b0, 0, 0);
`ifndef LZC_EARLY_OUT_EN
        n_vec++;
        if (bus.o_valid !== 1'b1 || bus.o_count !== 6'd2) begin
            n_fail++;
            $display("FAIL latency_frame1: o_valid=%0b o_count=%0d, required 1 and 2", bus.o_valid, bus.o_count);
        end
`endif
        frm = '{8'h00, 8'h00, 8'h0F, 8'h01};
        send_frame(frm, 4, 1'b0, 0, 0);
        frm = '{8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(frm, 4, 1'b0, 0, 0);
        send_frame(frm, 4, 1'b0, 1, 1);
        send_frame(frm, 2, 1'b0, 0, 0);
        frm = '{8'hFF, 8'hF0, 8'h00, 8'h00};
        send_frame(frm, 4, 1'b1, 0, 1);
        // Terminating bit in the first word: early-out timing differs.
        frm = '{8'h10, 8'hFF, 8'hFF, 8'hFF};
        drive_word(frm[0], 1'b0, 1'b0);
`ifdef LZC_EARLY_OUT_EN
        n_vec++;
        if (bus.o_valid !== 1'b1 || bus.o_count !== 6'd3) begin
            n_fail++;
            $display("FAIL early_out_latency: o_valid=%0b o_count=%0d, required 1 and 3", bus.o_valid, bus.o_count);
        end
`endif
        drive_word(frm[1], 1'b0, 1'b1);
        drive_word(frm[2], 1'b0, 1'b1);
        drive_word(frm[3], 1'b1, 1'b1);
`ifndef LZC_EARLY_OUT_EN
        n_vec++;
        if (bus.o_valid !== 1'b1 || bus.o_count !== 6'd3) begin
            n_fail++;
            $display("FAIL frame_end_latency: o_valid=%0b o_count=%0d, required 1 and 3", bus.o_valid, bus.o_count);
        end
`endif
        exp_q.push_back(model(frm, 4, 1'b0));
        wait_results();
        n_vec++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL directed_result_count: got %0d results, required %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_vec++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL directed_result: got count=%0d all=%0b, required count=%0d all=%0b", g[CNT_W-1:0], g[CNT_W], e[CNT_W-1:0], e[CNT_W]);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_backpressure();
        logic [7:0]     frm [4];
        logic [CNT_W:0] e, g;
        tb_ready = 1'b0;
        frm = '{8'h00, 8'h00, 8'h00, 8'h01};
        send_frame(frm, 4, 1'b0, 0, 0);
        bus.i_data  = 8'h05;
        bus.i_last  = 1'b1;
        bus.i_mode  = 1'b0;
        bus.i_valid = 1'b1;
        frm = '{8'h05, 8'h00, 8'h00, 8'h00};
        exp_q.push_back(model(frm, 1, 1'b0));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_vec++;
            if (bus.o_valid !== 1'b1 || bus.o_count !== 6'd31 || bus.i_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold: o_valid=%0b o_count=%0d i_ready=%0b, required 1, 31, 0", bus.o_valid, bus.o_count, bus.i_ready);
            end
        end
        @(posedge clk);
        #1;
        tb_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (bus.i_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release_i_ready: got %0b, required 1", bus.i_ready);
        end
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
        wait_results();
        n_vec++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL backpressure_result_count: got %0d results, required %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_vec++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL backpressure_result: got count=%0d all=%0b, required count=%0d all=%0b", g[CNT_W-1:0], g[CNT_W], e[CNT_W-1:0], e[CNT_W]);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset_midframe();
        logic [7:0]     frm [4];
        logic [CNT_W:0] e, g;
        drive_word(8'h00, 1'b0, 1'b0);
        drive_word(8'h00, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if (bus.o_valid !== 1'b0 || bus.o_count !== '0 || bus.o_all !== 1'b0 || bus.i_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_reset_outputs: o_valid=%0b o_count=%0d o_all=%0b i_ready=%0b, required all 0", bus.o_valid, bus.o_count, bus.o_all, bus.i_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        frm = '{8'h10, 8'($urandom), 8'($urandom), 8'($urandom)};
        send_frame(frm, 4, 1'b0, 0, 1);
        wait_results();
        n_vec++;
        if (got_q.size() != 1) begin
            n_fail++;
            $display("FAIL midframe_result_count: got %0d results, required 1", got_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_vec++;
            if (g !== e || g[CNT_W-1:0] !== 6'd3) begin
                n_fail++;
                $display("FAIL midframe_result: got count=%0d all=%0b, required count=%0d all=%0b", g[CNT_W-1:0], g[CNT_W], e[CNT_W-1:0], e[CNT_W]);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_random();
        logic [7:0]     frm [4];
        logic [CNT_W:0] e, g;
        logic           mode;
        int             n;
        rnd_ready = 1'b1;
        for (int f = 0; f < 60; f++) begin
            n    = $urandom_range(1, WORDS);
            mode = 1'($urandom);
            for (int i = 0; i < WORDS; i++) begin
                case ($urandom_range(0, 3))
                    0, 1:    frm[i] = {8{mode}};
                    2:       frm[i] = (8'h80 >> $urandom_range(0, 7)) ^ {8{mode}};
                    default: frm[i] = 8'($urandom);
                endcase
            end
            send_frame(frm, n, mode, 0, 2);
        end
        wait_results();
        rnd_ready = 1'b0;
        n_vec++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL random_result_count: got %0d results, required %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_vec++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL random_result: got count=%0d all=%0b, required count=%0d all=%0b", g[CNT_W-1:0], g[CNT_W], e[CNT_W-1:0], e[CNT_W]);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
